// File: rtl/hex_ascii_streamer.sv
// Latches one NUM_BYTES-wide word and streams its hex text one ASCII character
// per handshake, MSB nibble first, with optional "0x" prefix and CR/LF trailer.
module hex_ascii_streamer #(
    parameter int NUM_BYTES  = 2,
    parameter int ADD_PREFIX = 0,
    parameter int ADD_CRLF   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_BYTES*8-1:0] data_in,
    input  logic                   lower_case,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_char,
    output logic                   out_last,
    output logic                   busy
);
    localparam int W     = NUM_BYTES * 8;
    localparam int NDIG  = 2 * NUM_BYTES;
    localparam int PRE   = (ADD_PREFIX != 0) ? 2 : 0;
    localparam int EOLN  = (ADD_CRLF != 0) ? 2 : 0;
    localparam int TOTAL = NDIG + PRE + EOLN;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {IDLE, PREFIX, DIGITS, EOL} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     word_q;
    logic             lc_q;
    logic             accept;
    logic             xfer;
    logic             last_idx;
    int               nxt;

    function automatic logic [7:0] nib_ascii(input logic [3:0] n, input logic lc);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        return (lc ? 8'h61 : 8'h41) + {4'h0, n - 4'd10};
    endfunction

    // Character at word position p: prefix, then digits MSB first, then CR/LF.
    function automatic logic [7:0] char_at(input int p, input logic [W-1:0] w, input logic lc);
        logic [3:0] n;
        if (p < PRE)
            return (p == 0) ? 8'h30 : 8'h78;
        if (p < PRE + NDIG) begin
            n = 4'(w >> (4 * (NDIG - 1 - (p - PRE))));
            return nib_ascii(n, lc);
        end
        return (p == PRE + NDIG) ? 8'h0D : 8'h0A;
    endfunction

    function automatic state_t state_at(input int p);
        if (p < PRE)
            return PREFIX;
        if (p < PRE + NDIG)
            return DIGITS;
        return EOL;
    endfunction

    assign in_ready = (state == IDLE) & ~rst;
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign last_idx = (idx == IDX_W'(TOTAL - 1));
    assign nxt      = int'(idx) + 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            word_q    <= '0;
            lc_q      <= 1'b0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
        end else if (accept) begin
            word_q    <= data_in;
            lc_q      <= lower_case;
            idx       <= '0;
            state     <= state_at(0);
            out_valid <= 1'b1;
            out_char  <= char_at(0, data_in, lower_case);
            out_last  <= 1'b0;
        end else if (xfer) begin
            if (last_idx) begin
                // out_char keeps its final value; don't-care while out_valid=0
                state     <= IDLE;
                idx       <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                idx      <= idx + IDX_W'(1);
                state    <= state_at(nxt);
                out_char <= char_at(nxt, word_q, lc_q);
                out_last <= (nxt == TOTAL - 1);
            end
        end
    end
endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Directed bench for hex_ascii_streamer: default, prefix+CRLF and 4-byte builds.
module tb_hex_ascii_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    // instance 0: defaults
    logic        a_iv = 0, a_ir, a_lc = 0, a_ov, a_or = 1, a_ol, a_bz;
    logic [15:0] a_d = '0;
    logic [7:0]  a_oc;
    // instance 1: prefix + CRLF
    logic        b_iv = 0, b_ir, b_lc = 0, b_ov, b_or = 1, b_ol, b_bz;
    logic [15:0] b_d = '0;
    logic [7:0]  b_oc;
    // instance 2: 4-byte word
    logic        c_iv = 0, c_ir, c_lc = 0, c_ov, c_or = 1, c_ol, c_bz;
    logic [31:0] c_d = '0;
    logic [7:0]  c_oc;

    hex_ascii_streamer u0 (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .data_in(a_d),
        .lower_case(a_lc), .out_valid(a_ov), .out_ready(a_or), .out_char(a_oc),
        .out_last(a_ol), .busy(a_bz)
    );

    hex_ascii_streamer #(.NUM_BYTES(2), .ADD_PREFIX(1), .ADD_CRLF(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .data_in(b_d),
        .lower_case(b_lc), .out_valid(b_ov), .out_ready(b_or), .out_char(b_oc),
        .out_last(b_ol), .busy(b_bz)
    );

    hex_ascii_streamer #(.NUM_BYTES(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .data_in(c_d),
        .lower_case(c_lc), .out_valid(c_ov), .out_ready(c_or), .out_char(c_oc),
        .out_last(c_ol), .busy(c_bz)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One word on instance 0 with out_ready held high; exp holds 4 chars MSB first.
    task automatic word0(input string tag, input logic [15:0] d, input logic lc,
                         input logic [31:0] exp);
        chk({tag, "_rdy_pre"}, a_ir, 1);
        a_iv = 1; a_d = d; a_lc = lc; a_or = 1;
        tick;
        a_iv = 0; a_d = 16'h0000; a_lc = ~lc;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, a_ov, 1);
            chk({tag, "_char"}, a_oc, exp[31-8*i -: 8]);
            chk({tag, "_last"}, a_ol, (i == 3) ? 1 : 0);
            chk({tag, "_busy"}, a_bz, 1);
            chk({tag, "_rdy_busy"}, a_ir, 0);
            tick;
        end
        chk({tag, "_valid_end"}, a_ov, 0);
        chk({tag, "_rdy_end"}, a_ir, 1);
        chk({tag, "_busy_end"}, a_bz, 0);
    endtask

    initial begin
        logic [63:0] e8;
        logic [31:0] e4;
        logic [6:0]  pat;
        int          k;

        // reset state
        tick;
        tick;
        chk("rst_valid", a_ov, 0);
        chk("rst_char", a_oc, 8'h00);
        chk("rst_last", a_ol, 0);
        chk("rst_busy", a_bz, 0);
        chk("rst_ready", a_ir, 0);
        chk("rst_ready_b", b_ir, 0);
        rst = 0;
        #1;
        chk("post_rst_ready", a_ir, 1);

        // basic words, upper and lower case
        word0("w1234", 16'h1234, 1'b0, 32'h31323334);
        word0("wabcd_lc", 16'hABCD, 1'b1, 32'h61626364);
        word0("wabcd_uc", 16'hABCD, 1'b0, 32'h41424344);

        // prefix + CRLF build
        e8 = 64'h3078_4630_4531_0D0A;
        chk("pfx_rdy", b_ir, 1);
        b_iv = 1; b_d = 16'hF0E1; b_lc = 0;
        tick;
        b_iv = 0;
        for (int i = 0; i < 8; i++) begin
            chk("pfx_valid", b_ov, 1);
            chk("pfx_char", b_oc, e8[63-8*i -: 8]);
            chk("pfx_last", b_ol, (i == 7) ? 1 : 0);
            tick;
        end
        chk("pfx_valid_end", b_ov, 0);
        chk("pfx_rdy_end", b_ir, 1);

        // backpressure with mid-word data change
        e4 = 32'h30304646;
        pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
        a_iv = 1; a_d = 16'h00FF; a_lc = 0;
        tick;
        a_iv = 0; a_d = 16'h9999;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            a_or = pat[i];
            chk("bp_valid", a_ov, 1);
            chk("bp_char", a_oc, e4[31-8*k -: 8]);
            chk("bp_last", a_ol, (k == 3) ? 1 : 0);
            tick;
            if (pat[i]) k++;
        end
        a_or = 1;
        chk("bp_count", k, 4);
        chk("bp_valid_end", a_ov, 0);
        chk("bp_rdy_end", a_ir, 1);

        // reset in the middle of a word
        a_iv = 1; a_d = 16'h1234; a_lc = 0;
        tick;
        a_iv = 0;
        chk("mrst_c0", a_oc, 8'h31);
        tick;
        chk("mrst_c1", a_oc, 8'h32);
        tick;
        chk("mrst_c2", a_oc, 8'h33);
        rst = 1;
        #1;
        chk("mrst_rdy_in_rst", a_ir, 0);
        tick;
        chk("mrst_valid", a_ov, 0);
        chk("mrst_busy", a_bz, 0);
        chk("mrst_rdy", a_ir, 0);
        rst = 0;
        #1;
        chk("mrst_rdy_after", a_ir, 1);
        word0("w5678", 16'h5678, 1'b0, 32'h35363738);

        // 4-byte build, back-to-back with in_valid held high
        e8 = 64'h4445_4144_4245_4546;
        c_iv = 1; c_d = 32'hDEADBEEF; c_lc = 0;
        tick;
        c_d = 32'h01234567;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_w0_char", c_oc, e8[63-8*i -: 8]);
            chk("b2b_w0_last", c_ol, (i == 7) ? 1 : 0);
            chk("b2b_w0_rdy", c_ir, 0);
            tick;
        end
        chk("b2b_gap_valid", c_ov, 0);
        chk("b2b_gap_rdy", c_ir, 1);
        tick;
        c_iv = 0;
        e8 = 64'h3031_3233_3435_3637;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_w1_valid", c_ov, 1);
            chk("b2b_w1_char", c_oc, e8[63-8*i -: 8]);
            chk("b2b_w1_last", c_ol, (i == 7) ? 1 : 0);
            tick;
        end
        chk("b2b_end_valid", c_ov, 0);
        chk("b2b_end_busy", c_bz, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hex_ascii_streamer.md
Name: hex_ascii_streamer

Overview:
- Sequential, parametrised successor to the combinational hex-to-ASCII translator.
- Accepts one NUM_BYTES-wide word per valid/ready handshake.
- Emits its hexadecimal representation one ASCII character per handshake on an 8-bit valid/ready stream, MSB nibble first. The stream feeds the UART TX path directly.
- Adds three features: upper/lower-case letter mode, an optional "0x" prefix, and an optional CR/LF terminator.

Parameters:
- NUM_BYTES, 2, bytes per input word; integer ≥ 1. Produces 2*NUM_BYTES digit characters.
- ADD_PREFIX, 0, when 1 each word is preceded by "0x" (0x30, 0x78).
- ADD_CRLF, 0, when 1 each word is followed by CR then LF (0x0D, 0x0A).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in/lower_case are valid.
- in_ready  output  1  block can accept a word.
- data_in  input  NUM_BYTES*8  word to convert.
- lower_case  input  1  digit mode: 1 maps A-F to 0x61-0x66; 0 maps A-F to 0x41-0x46. Sampled at accept.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  downstream accepts out_char.
- out_char  output  8  current ASCII character.
- out_last  output  1  out_char is the final character of the current word.
- busy  output  1  a word is latched and not fully emitted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; the internal character index clears.
  - out_valid=0, out_char=0x00, out_last=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
  - Reset mid-word abandons the word; the next word starts cleanly.
- States: IDLE, PREFIX, DIGITS, EOL.
- in_ready = (state==IDLE) & ~rst. Words are never accepted while busy, so there is no accept on the same cycle as the last output handshake.
- Accept: in_valid & in_ready at edge N.
  - Latch data_in and lower_case.
  - Next state is PREFIX if ADD_PREFIX, else DIGITS.
  - out_valid=1 with the first character in cycle N+1 (1-cycle latency).
- Output handshake: a character transfers on an edge where out_valid & out_ready.
  - While out_valid & ~out_ready, out_char and out_last hold stable.
  - Changes to data_in/lower_case after accept have no effect.
- PREFIX: emits 0x30 then 0x78 ('x' stays lower case regardless of lower_case), then goes to DIGITS.
- DIGITS: emits nibble k (k = 2*NUM_BYTES-1 down to 0) of the latched word.
  - Nibble 0-9 maps to 0x30+n.
  - Nibble 10-15 maps to 0x41+(n-10) when upper case, 0x61+(n-10) when lower case.
  - After nibble 0: go to EOL if ADD_CRLF, else IDLE.
- EOL: emits 0x0D then 0x0A, then goes to IDLE.
- out_last=1 exactly on the final character: LF if ADD_CRLF, else nibble 0.
- After the final handshake at edge M:
  - out_valid=0 and in_ready=1 in cycle M+1.
  - out_char holds its last value; its value is don't-care when out_valid=0.
- busy=1 from the cycle after accept until the cycle after the final handshake.
- Characters per word = 2*NUM_BYTES + 2*ADD_PREFIX + 2*ADD_CRLF.
- With out_ready held at 1, a word occupies exactly that many cycles plus 1 idle/accept cycle.
- Character index width = clog2 of the total character count, minimum 1 bit. No wrap beyond the count.
- NUM_BYTES=1 must work (2 digits).
- in_valid with in_ready=0 is ignored; the source must hold the word until in_ready.

Test Plan:
- Default params, out_ready=1, accept 0x1234 with lower_case=0 → out_char sequence 0x31,0x32,0x33,0x34 on consecutive cycles starting one cycle after accept; out_last only on 0x34; in_ready=1 the cycle after.
- Accept 0xABCD with lower_case=1 → 0x61,0x62,0x63,0x64. Repeat with lower_case=0 → 0x41,0x42,0x43,0x44.
- ADD_PREFIX=1, ADD_CRLF=1, accept 0xF0E1 upper case → 0x30,0x78,0x46,0x30,0x45,0x31,0x0D,0x0A (8 chars); out_last on 0x0A only.
- Backpressure: accept 0x00FF, toggle out_ready 1,0,0,1,0,1,1 → each char held stable during stalls; sequence 0x30,0x30,0x46,0x46 unchanged; data_in changed to 0x9999 mid-word has no effect.
- Reset mid-word: after 2 characters of 0x1234, pulse rst one cycle → out_valid=0, busy=0, in_ready=0 during rst and 1 after. The next word 0x5678 yields 0x35,0x36,0x37,0x38.
- NUM_BYTES=4, back-to-back in_valid held high with 0xDEADBEEF then 0x01234567 → 8 digits each; second word accepted only the cycle after the first word's out_last handshake.
